// File: rtl/fetch_queue_unit.sv
// Instruction fetcher with static JAL / predicted-branch next-PC logic and a
// circular fetch queue feeding the dispatcher over a valid/ready handshake.
module fetch_queue_unit #(
    parameter int              ADDR_W      = 32,
    parameter int              INST_W      = 32,
    parameter int              QUEUE_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter bit              PRED_EN     = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_done_in,
    input  logic [INST_W-1:0] mem_inst_in,
    output logic [ADDR_W-1:0] pred_pc_out,
    input  logic              pred_taken_in,
    input  logic              flush_in,
    input  logic [ADDR_W-1:0] flush_pc_in,
    output logic              disp_valid_out,
    input  logic              disp_ready_in,
    output logic [INST_W-1:0] disp_inst_out,
    output logic [ADDR_W-1:0] disp_pc_out,
    output logic              disp_pred_out
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_upd;

    logic [INST_W-1:0] inst_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0] pc_q   [QUEUE_DEPTH];
    logic              pred_q [QUEUE_DEPTH];

    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] next_pc;
    logic              next_pred;

    function automatic logic signed [ADDR_W-1:0] jal_off(input logic [INST_W-1:0] inst);
        return {{(ADDR_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic signed [ADDR_W-1:0] br_off(input logic [INST_W-1:0] inst);
        return {{(ADDR_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    always_comb begin
        next_pc   = pc + ADDR_W'(4);
        next_pred = 1'b0;
        if (mem_inst_in[6:0] == OP_JAL) begin
            next_pc   = pc + $unsigned(jal_off(mem_inst_in));
            next_pred = 1'b1;
        end else if (mem_inst_in[6:0] == OP_BRANCH && PRED_EN && pred_taken_in) begin
            next_pc   = pc + $unsigned(br_off(mem_inst_in));
            next_pred = 1'b1;
        end
    end

    assign disp_valid_out = (count != '0);
    assign pop       = rdy_in && disp_valid_out && disp_ready_in;
    // A completion that races a flush, or lands in DROP, is never stored.
    assign push      = rdy_in && mem_done_in && (state == ST_WAIT) && !flush_in;
    assign count_upd = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            if (pop) head <= head + PTR_W'(1);
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                pc    <= flush_pc_in & ~ADDR_W'(3);
                case (state)
                    ST_WAIT, ST_DROP: state <= mem_done_in ? ST_IDLE : ST_DROP;
                    default:          state <= ST_IDLE;
                endcase
            end else begin
                count <= count_upd;
                if (push) tail <= tail + PTR_W'(1);
                case (state)
                    ST_IDLE: begin
                        if (count < FULL) begin
                            state  <= ST_WAIT;
                            addr_q <= pc;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_done_in) begin
                            pc <= next_pc;
                            if (count_upd < FULL) addr_q <= next_pc;
                            else                  state  <= ST_IDLE;
                        end
                    end
                    ST_DROP: if (mem_done_in) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_q[tail] <= mem_inst_in;
            pc_q[tail]   <= pc;
            pred_q[tail] <= next_pred;
        end
    end

    // Address register stays put through DROP even though pc already moved.
    assign mem_req_out   = (state == ST_WAIT) || (state == ST_DROP);
    assign mem_addr_out  = addr_q;
    assign pred_pc_out   = pc;
    assign disp_inst_out = disp_valid_out ? inst_q[head] : '0;
    assign disp_pc_out   = disp_valid_out ? pc_q[head]   : '0;
    assign disp_pred_out = disp_valid_out ? pred_q[head] : 1'b0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: scoreboarded fetch stream, next-PC vector table,
// and hand-written flush / stall / reset sequences.
module tb_fetch_queue_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_done_in;
    logic [31:0] mem_inst_in;
    logic [31:0] pred_pc_out;
    logic        pred_taken_in;
    logic        flush_in;
    logic [31:0] flush_pc_in;
    logic        disp_valid_out;
    logic        disp_ready_in;
    logic [31:0] disp_inst_out;
    logic [31:0] disp_pc_out;
    logic        disp_pred_out;

    logic        np_mem_req, np_disp_valid, np_disp_pred;
    logic [31:0] np_mem_addr, np_pred_pc, np_disp_inst, np_disp_pc;

    fetch_queue_unit #(.ADDR_W(32), .INST_W(32), .QUEUE_DEPTH(8), .RESET_PC(32'h0), .PRED_EN(1'b1)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_done_in(mem_done_in), .mem_inst_in(mem_inst_in),
        .pred_pc_out(pred_pc_out), .pred_taken_in(pred_taken_in),
        .flush_in(flush_in), .flush_pc_in(flush_pc_in),
        .disp_valid_out(disp_valid_out), .disp_ready_in(disp_ready_in),
        .disp_inst_out(disp_inst_out), .disp_pc_out(disp_pc_out), .disp_pred_out(disp_pred_out)
    );

    fetch_queue_unit #(.ADDR_W(32), .INST_W(32), .QUEUE_DEPTH(8), .RESET_PC(32'h0), .PRED_EN(1'b0)) u_np (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req_out(np_mem_req), .mem_addr_out(np_mem_addr),
        .mem_done_in(mem_done_in), .mem_inst_in(mem_inst_in),
        .pred_pc_out(np_pred_pc), .pred_taken_in(pred_taken_in),
        .flush_in(flush_in), .flush_pc_in(flush_pc_in),
        .disp_valid_out(np_disp_valid), .disp_ready_in(disp_ready_in),
        .disp_inst_out(np_disp_inst), .disp_pc_out(np_disp_pc), .disp_pred_out(np_disp_pred)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } sb_entry_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] exp_next;
        logic        exp_pred;
        logic [31:0] exp_next_np;
    } vec_t;

    sb_entry_t   sbq[$];
    int          checks = 0;
    int          passes = 0;
    int          pushes = 0;
    int          pops   = 0;
    int          age    = 0;
    int          mem_lat = 1;
    bit          auto_mem = 1'b1;
    bit          drop_pend = 1'b0;
    logic [31:0] exp_pc = 32'h0;

    localparam logic [31:0] ADDI = 32'h00100093;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0100006F;   // jal x0,+16
            32'h200: return 32'hFE000CE3;   // beq -8
            32'h300: return 32'h000080E7;   // jalr
            32'h500: return 32'hFF1FF06F;   // jal x0,-16
            default: return ADDI;
        endcase
    endfunction

    // Returns {pred, next_pc}
    function automatic logic [32:0] ref_next(input logic [31:0] pc, input logic [31:0] inst, input logic tk);
        logic [31:0] off;
        if (inst[6:0] == 7'h6F) begin
            off = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            return {1'b1, pc + off};
        end
        if (inst[6:0] == 7'h63 && tk) begin
            off = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            return {1'b1, pc + off};
        end
        return {1'b0, pc + 32'd4};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        logic      pop, done;
        logic [32:0] nx;
        sb_entry_t e;
        if (auto_mem) begin
            mem_done_in = 1'b0;
            if (rdy_in && mem_req_out) begin
                age++;
                if (age >= mem_lat) begin
                    mem_done_in = 1'b1;
                    age = 0;
                end
            end
            mem_inst_in = imem(mem_addr_out);
        end
        pop  = rdy_in && disp_valid_out && disp_ready_in;
        done = rdy_in && mem_done_in && mem_req_out;
        if (pop) begin
            pops++;
            if (sbq.size() == 0) chk("pop_on_empty", disp_valid_out, 0);
            else begin
                e = sbq.pop_front();
                chk("disp_pc", disp_pc_out, e.pc);
                chk("disp_inst", disp_inst_out, e.inst);
                chk("disp_pred", disp_pred_out, e.pred);
            end
        end
        if (rdy_in && flush_in) begin
            sbq.delete();
            drop_pend = mem_req_out && !done;
            exp_pc = flush_pc_in & ~32'h3;
        end else if (done) begin
            if (drop_pend) drop_pend = 1'b0;
            else begin
                chk("fetch_addr", mem_addr_out, exp_pc);
                nx = ref_next(exp_pc, mem_inst_in, pred_taken_in);
                e.inst = mem_inst_in;
                e.pc   = exp_pc;
                e.pred = nx[32];
                sbq.push_back(e);
                pushes++;
                exp_pc = nx[31:0];
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        flush_in = 1'b0;
        flush_pc_in = 32'h0;
        mem_done_in = 1'b0;
        mem_inst_in = 32'h0;
        pred_taken_in = 1'b0;
        disp_ready_in = 1'b1;
        auto_mem = 1'b1;
        mem_lat = 1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        chk("rst_req", mem_req_out, 0);
        chk("rst_addr", mem_addr_out, 32'h0);
        chk("rst_valid", disp_valid_out, 0);
        chk("rst_disp_pc", disp_pc_out, 0);
        sbq.delete();
        drop_pend = 1'b0;
        exp_pc = 32'h0;
        age = 0;
        rst_in = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h100,        1'b0, 32'h110, 1'b1, 32'h110};
        vecs[1] = '{32'h200,        1'b1, 32'h1F8, 1'b1, 32'h204};
        vecs[2] = '{32'h200,        1'b0, 32'h204, 1'b0, 32'h204};
        vecs[3] = '{32'h300,        1'b1, 32'h304, 1'b0, 32'h304};
        vecs[4] = '{32'h500,        1'b0, 32'h4F0, 1'b1, 32'h4F0};
        vecs[5] = '{32'hFFFF_FFFC,  1'b0, 32'h0,   1'b0, 32'h0};

        // back-to-back fetch at 0,4,8
        do_reset();
        tick();
        chk("first_req", mem_req_out, 1);
        chk("first_addr", mem_addr_out, 32'h0);
        tick();
        chk("lat_valid", disp_valid_out, 1);
        chk("lat_pc", disp_pc_out, 32'h0);
        chk("b2b_addr4", mem_addr_out, 32'h4);
        tick();
        chk("b2b_pc4", disp_pc_out, 32'h4);
        chk("b2b_addr8", mem_addr_out, 32'h8);
        tick();
        chk("b2b_pc8", disp_pc_out, 32'h8);

        // next-PC vector table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            flush_in = 1'b1;
            flush_pc_in = vecs[i].pc;
            tick();
            flush_in = 1'b0;
            pred_taken_in = vecs[i].taken;
            tick();
            chk($sformatf("v%0d_req_addr", i), mem_addr_out, vecs[i].pc);
            tick();
            chk($sformatf("v%0d_next", i), mem_addr_out, vecs[i].exp_next);
            chk($sformatf("v%0d_next_np", i), np_mem_addr, vecs[i].exp_next_np);
            chk($sformatf("v%0d_pred", i), disp_pred_out, vecs[i].exp_pred);
            chk($sformatf("v%0d_head_pc", i), disp_pc_out, vecs[i].pc);
        end

        // stalled dispatcher fills queue to exactly 8
        do_reset();
        disp_ready_in = 1'b0;
        pushes = 0;
        pops = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("full_pushes", pushes, 8);
        chk("full_req_low", mem_req_out, 0);
        // frozen with a full queue, dispatcher ready must not pop
        rdy_in = 1'b0;
        disp_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_full_req", mem_req_out, 0);
            chk("frz_full_valid", disp_valid_out, 1);
            chk("frz_full_head", disp_pc_out, 32'h0);
        end
        rdy_in = 1'b1;
        tick();
        disp_ready_in = 1'b0;
        chk("pop_req_still_low", mem_req_out, 0);
        tick();
        chk("refill_req", mem_req_out, 1);
        chk("refill_addr", mem_addr_out, 32'h20);
        for (int i = 0; i < 80; i++) begin
            disp_ready_in = 1'($urandom_range(0, 1));
            tick();
        end
        chk("wrap_pops_ge20", pops >= 20, 1);

        // flush while in WAIT, stale completion 3 cycles later
        do_reset();
        disp_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        auto_mem = 1'b0;
        mem_done_in = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_wait_req", mem_req_out, 1);
            chk("frz_wait_addr", mem_addr_out, 32'hC);
            chk("frz_wait_head", disp_pc_out, 32'h0);
        end
        rdy_in = 1'b1;
        flush_in = 1'b1;
        flush_pc_in = 32'h403;
        tick();
        flush_in = 1'b0;
        chk("fl_empty", disp_valid_out, 0);
        chk("fl_pred_pc", pred_pc_out, 32'h400);
        tick();
        tick();
        chk("drop_req_held", mem_req_out, 1);
        mem_done_in = 1'b1;
        mem_inst_in = ADDI;
        tick();
        mem_done_in = 1'b0;
        chk("drop_no_push", disp_valid_out, 0);
        chk("drop_idle", mem_req_out, 0);
        tick();
        chk("fl_req", mem_req_out, 1);
        chk("fl_addr", mem_addr_out, 32'h400);

        // flush coincident with completion and pop
        do_reset();
        tick();
        tick();
        tick();
        chk("co_pre_valid", disp_valid_out, 1);
        chk("co_pre_head", disp_pc_out, 32'h4);
        flush_in = 1'b1;
        flush_pc_in = 32'h600;
        tick();
        flush_in = 1'b0;
        chk("co_empty", disp_valid_out, 0);
        chk("co_idle", mem_req_out, 0);
        tick();
        chk("co_req", mem_req_out, 1);
        chk("co_addr", mem_addr_out, 32'h600);
        chk("co_still_empty", disp_valid_out, 0);

        // async reset mid-WAIT, then a late completion in IDLE
        do_reset();
        mem_lat = 3;
        tick();
        tick();
        chk("ar_pre_req", mem_req_out, 1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("ar_req", mem_req_out, 0);
        chk("ar_addr", mem_addr_out, 32'h0);
        chk("ar_valid", disp_valid_out, 0);
        chk("ar_pred_pc", pred_pc_out, 32'h0);
        @(posedge clk_in);
        #1;
        sbq.delete();
        drop_pend = 1'b0;
        exp_pc = 32'h0;
        age = 0;
        rst_in = 1'b1;
        auto_mem = 1'b0;
        mem_done_in = 1'b1;
        mem_inst_in = 32'h0100006F;
        tick();
        mem_done_in = 1'b0;
        chk("late_done_valid", disp_valid_out, 0);
        chk("late_done_req", mem_req_out, 1);
        chk("late_done_addr", mem_addr_out, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
